// File: rtl/sobel_pkg.sv
// sobel_pkg: pixel and row types shared by the Sobel filter and its row serializer.
package sobel_pkg;
  localparam int PIX_W = 8;
  localparam int SOBEL_W = 98;
  localparam int SOBEL_H = 98;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t row_t [SOBEL_W];
endpackage

// File: rtl/sobel_row_fifo.sv
// sobel_row_fifo: DEPTH-row buffer of whole rows; exposes the head row for pixel readout.
module sobel_row_fifo
  import sobel_pkg::*;
#(
  parameter int WIDTH = SOBEL_W,
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  pixel_t row_in [WIDTH],
  output pixel_t head [WIDTH],
  output logic   full,
  output logic   empty
);
  localparam int PW = $clog2(DEPTH);
  pixel_t mem [DEPTH][WIDTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head = mem[rd_q];
  // Row storage is deliberately left out of reset.
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= row_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sobel_row_serializer.sv
// sobel_row_serializer: buffers parallel filter rows and streams them one pixel per beat,
// flagging end-of-row/frame and sticky-dropping rows offered while the buffer is full.
module sobel_row_serializer
  import sobel_pkg::*;
#(
  parameter int WIDTH = SOBEL_W,
  parameter int HEIGHT = SOBEL_H,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        row_valid,
  input  pixel_t      row_in [WIDTH],
  output logic        row_ready,
  output pixel_t      pix_out,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        drop_err,
  output logic [15:0] frames_done
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT-1);
  logic full, empty, push, beat, pop, last_col, last_row;
  pixel_t head [WIDTH];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [15:0] frames_q, frames_d;
  logic drop_q;
  sobel_row_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .row_in(row_in),
    .head(head), .full(full), .empty(empty)
  );
  // row_ready comes from pre-pop occupancy: a full buffer rejects even on its pop cycle.
  assign row_ready = !full;
  assign push = row_valid && !full;
  assign pix_valid = !empty;
  assign beat = pix_valid && pix_ready;
  assign last_col = col_q == COL_LAST;
  assign last_row = row_q == ROW_LAST;
  assign pop = beat && last_col;
  assign pix_out = pix_valid ? head[col_q] : '0;
  assign pix_eol = pix_valid && last_col;
  assign pix_eof = pix_eol && last_row;
  assign drop_err = drop_q;
  assign frames_done = frames_q;
  always_comb begin
    col_d = !beat ? col_q : last_col ? '0 : col_q + CW'(1);
    row_d = !pop ? row_q : last_row ? '0 : row_q + RW'(1);
    frames_d = frames_q + 16'(pop && last_row);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      frames_q <= '0;
      drop_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      frames_q <= frames_d;
      if (row_valid && full) drop_q <= 1'b1;
    end
endmodule

// File: tb/tb_sobel_row_serializer.sv
// tb_sobel_row_serializer: randomized stimulus checked every cycle against a pixel-queue model.
module tb_sobel_row_serializer;
  localparam int W = 98;
  localparam int H = 98;
  localparam int D = 2;
  typedef struct {
    logic [7:0] p;
    bit eol;
    bit eof;
  } px_t;
  logic clk = 0;
  logic rst, row_valid, pix_ready;
  logic [7:0] row_in [W];
  logic row_ready, pix_valid, pix_eol, pix_eof, drop_err;
  logic [7:0] pix_out;
  logic [15:0] frames_done;
  px_t q[$];
  int accepted, done_rows, frames, total, bad, beats, dut_eof_cnt, dut_eof_beat, dut_eol_cnt;
  bit drop_m;
  always #5 clk = ~clk;
  sobel_row_serializer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .row_valid(row_valid), .row_in(row_in), .row_ready(row_ready),
    .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_eol(pix_eol),
    .pix_eof(pix_eof), .drop_err(drop_err), .frames_done(frames_done)
  );
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  function automatic bit m_ready();
    return (accepted - done_rows) < D;
  endfunction
  task automatic compare();
    chk("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
    chk("pix_out", 32'(pix_out), q.size() != 0 ? 32'(q[0].p) : 0);
    chk("pix_eol", 32'(pix_eol), q.size() != 0 ? 32'(q[0].eol) : 0);
    chk("pix_eof", 32'(pix_eof), q.size() != 0 ? 32'(q[0].eof) : 0);
    chk("row_ready", 32'(row_ready), 32'(m_ready()));
    chk("drop_err", 32'(drop_err), 32'(drop_m));
    chk("frames_done", 32'(frames_done), 32'(frames[15:0]));
  endtask
  task automatic clear_model();
    q.delete();
    accepted = 0;
    done_rows = 0;
    frames = 0;
    drop_m = 0;
    beats = 0;
    dut_eof_cnt = 0;
    dut_eol_cnt = 0;
    dut_eof_beat = 0;
  endtask
  // Called at a falling edge: check, drive, advance the model, wait one clock.
  task automatic cyc(bit rv, bit pr);
    bit rdy;
    px_t px;
    compare();
    row_valid = rv;
    pix_ready = pr;
    #1;
    if (pix_valid && pr) begin
      beats++;
      if (pix_eol) dut_eol_cnt++;
      if (pix_eof) begin
        dut_eof_cnt++;
        dut_eof_beat = beats;
      end
    end
    rdy = m_ready();
    if (rv && !rdy) drop_m = 1;
    if (q.size() != 0 && pr) begin
      px = q.pop_front();
      if (px.eol) done_rows++;
      if (px.eof) frames++;
    end
    if (rv && rdy) begin
      for (int i = 0; i < W; i++)
        q.push_back('{row_in[i], i == W-1, i == W-1 && accepted % H == H-1});
      accepted++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rand_row();
    for (int i = 0; i < W; i++) row_in[i] = 8'($urandom);
  endtask
  task automatic do_reset();
    rst = 1;
    row_valid = 0;
    pix_ready = 0;
    #1;
    chk("rst_row_ready", 32'(row_ready), 1);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_out", 32'(pix_out), 0);
    chk("rst_frames", 32'(frames_done), 0);
    chk("rst_drop", 32'(drop_err), 0);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < W; i++) row_in[i] = 0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < W; i++) row_in[i] = 8'(i);
    cyc(1, 1);
    chk("first_valid", 32'(pix_valid), 1);
    chk("first_pix", 32'(pix_out), 0);
    for (int i = 0; i < W; i++) begin
      if (pix_eol) chk("eol_value", 32'(pix_out), 97);
      cyc(0, 1);
    end
    chk("row_drained_valid", 32'(pix_valid), 0);
    chk("row_drained_ready", 32'(row_ready), 1);
    chk("eol_count", 32'(dut_eol_cnt), 1);
    rand_row();
    cyc(1, 0);
    for (int i = 0; i < 2 * W; i++) cyc(0, i % 2 == 0);
    for (int i = 0; i < W; i++) row_in[i] = 8'(i);
    cyc(1, 0);
    for (int i = 0; i < W; i++) row_in[i] = 8'(i + 100);
    cyc(1, 0);
    chk("full_ready", 32'(row_ready), 0);
    rand_row();
    cyc(1, 0);
    chk("drop_set", 32'(drop_err), 1);
    for (int i = 0; i < W-1; i++) cyc(0, 1);
    for (int i = 0; i < W; i++) row_in[i] = 8'(255 - i);
    chk("pop_cycle_ready", 32'(row_ready), 0);
    cyc(1, 1);
    chk("after_pop_ready", 32'(row_ready), 1);
    cyc(1, 1);
    for (int i = 0; i < 3 * W && q.size() != 0; i++) cyc(0, 1);
    chk("drained", 32'(q.size()), 0);
    chk("drop_sticky", 32'(drop_err), 1);
    for (int n = 0; n < 3000; n++) begin
      rand_row();
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    do_reset();
    for (int n = 0; n < 20000 && accepted < H; n++) begin
      rand_row();
      cyc(1, 1);
    end
    for (int n = 0; n < 2 * W && q.size() != 0; n++) cyc(0, 1);
    chk("frame_rows", 32'(accepted), H);
    chk("frame_drained", 32'(q.size()), 0);
    chk("eof_count", 32'(dut_eof_cnt), 1);
    chk("eof_beat", 32'(dut_eof_beat), 9604);
    chk("frame_done", 32'(frames_done), 1);
    chk("frame_drop", 32'(drop_err), 1);
    compare();
    for (int i = 0; i < W; i++) row_in[i] = 8'(i + 7);
    cyc(1, 1);
    for (int i = 0; i < 40; i++) cyc(0, 1);
    chk("midrow_pix", 32'(pix_out), 47);
    #2 rst = 1;
    #1;
    chk("async_valid", 32'(pix_valid), 0);
    chk("async_ready", 32'(row_ready), 1);
    chk("async_pix", 32'(pix_out), 0);
    chk("async_eol", 32'(pix_eol), 0);
    chk("async_frames", 32'(frames_done), 0);
    chk("async_drop", 32'(drop_err), 0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < W; i++) row_in[i] = 8'(200 - i);
    cyc(1, 0);
    chk("restart_pix", 32'(pix_out), 200);
    chk("restart_frames", 32'(frames_done), 0);
    for (int n = 0; n < 2 * W && q.size() != 0; n++) cyc(0, 1);
    compare();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
